ram_inport_responder: RTL and testbench

RAM_INPORT_RESPONDER -- requirements
Module: ram_inport_responder

---
 rtl/ram_inport_responder_if.sv | 25 ++
 rtl/ram_inport_responder.sv | 135 +++++++++++++
 tb/tb_ram_inport_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_inport_responder_if.sv
// Request/response port bundle for the RAM inport responder.
// The master (initiator) drives the request fields. The slave (responder)
// drives the accept and response fields.
interface ram_inport_responder_if;
  logic [15:0]  inport_wr_i;
  logic         inport_rd_i;
  logic [31:0]  inport_addr_i;
  logic [127:0] inport_write_data_i;
  logic [15:0]  inport_req_id_i;
  logic         inport_accept_o;
  logic         inport_ack_o;
  logic         inport_error_o;
  logic [15:0]  inport_resp_id_o;
  logic [127:0] inport_read_data_o;

  modport master (
    output inport_wr_i, inport_rd_i, inport_addr_i, inport_write_data_i, inport_req_id_i,
    input  inport_accept_o, inport_ack_o, inport_error_o, inport_resp_id_o, inport_read_data_o
  );

  modport slave (
    input  inport_wr_i, inport_rd_i, inport_addr_i, inport_write_data_i, inport_req_id_i,
    output inport_accept_o, inport_ack_o, inport_error_o, inport_resp_id_o, inport_read_data_o
  );
endinterface

// File: rtl/ram_inport_responder.sv
// Fixed-latency 128-bit RAM responder.
// Each accepted request performs its RAM access on the accepting edge. A tagged
// response then moves down a non-stalling shift register. Its ack appears
// RESP_LATENCY cycles later. An optional accept gap throttles the request rate.
// RAM contents are never reset, so they survive a reset of the control logic.
module ram_inport_responder #(
  parameter int DEPTH_W      = 6,   // log2 of word count
  parameter int RESP_LATENCY = 4,   // 1..16
  parameter int ACCEPT_GAP   = 0    // 0..15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ram_inport_responder_if.slave inport
);
  localparam int         WORDS    = 1 << DEPTH_W;
  localparam logic [3:0] GAP_INIT = 4'(ACCEPT_GAP);

  logic               r_accept;
  logic [3:0]         r_gap;
  logic [127:0]       r_mem [WORDS];
  logic [127:0]       r_mem_q;

  logic               w_has_wr;
  logic               w_req;
  logic               w_acc;
  logic [31:0]        w_addr_hi;
  logic               w_oor;
  logic               w_err;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic [DEPTH_W-1:0] w_idx;

  // Stage outputs of the response pipeline. Index 0 is the youngest stage.
  logic               w_vld  [RESP_LATENCY];
  logic [15:0]        w_id   [RESP_LATENCY];
  logic               w_errs [RESP_LATENCY];
  logic [127:0]       w_data [RESP_LATENCY];

  assign w_has_wr  = |inport.inport_wr_i;
  assign w_req     = w_has_wr | inport.inport_rd_i;
  assign w_acc     = w_req & r_accept;
  // Any set address bit above the RAM's word index means the address is out of range.
  assign w_addr_hi = inport.inport_addr_i >> (DEPTH_W + 4);
  assign w_oor     = |w_addr_hi;
  assign w_err     = w_oor | (w_has_wr & inport.inport_rd_i);
  assign w_wr_ok   = w_acc & w_has_wr & ~w_err;
  assign w_rd_ok   = w_acc & inport.inport_rd_i & ~w_err;
  assign w_idx     = inport.inport_addr_i[DEPTH_W+3:4];

  // Accept throttle: accept is high exactly when the gap counter is zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_accept <= 1'b0;
      r_gap    <= 4'd0;
    end else if (w_acc) begin
      r_gap    <= GAP_INIT;
      r_accept <= (GAP_INIT == 4'd0);
    end else if (r_gap != 4'd0) begin
      r_gap    <= r_gap - 4'd1;
      r_accept <= (r_gap == 4'd1);
    end else begin
      r_accept <= 1'b1;
    end
  end

  // RAM: byte-masked write and registered read. Reset does not touch it.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) begin
      for (int b = 0; b < 16; b++) begin
        if (inport.inport_wr_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= inport.inport_write_data_i[8*b +: 8];
        end
      end
    end
    if (w_rd_ok) begin
      r_mem_q <= r_mem[w_idx];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RESP_LATENCY; gi++) begin : g_stage
      logic        r_vld;
      logic [15:0] r_id;
      logic        r_err;

      if (gi == 0) begin : g_head
        logic r_rd;
        // Stage 0 captures the new response. Its fields are zero when no request is accepted.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_vld <= 1'b0;
            r_id  <= 16'd0;
            r_err <= 1'b0;
            r_rd  <= 1'b0;
          end else begin
            r_vld <= w_acc;
            r_id  <= w_acc ? inport.inport_req_id_i : 16'd0;
            r_err <= w_acc & w_err;
            r_rd  <= w_rd_ok;
          end
        end
        // Only a good read carries RAM data. Writes and errors return zero.
        assign w_data[gi] = r_rd ? r_mem_q : 128'd0;
      end else begin : g_tail
        logic [127:0] r_data;
        // Later stages shift one position every cycle, with no stall.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_vld  <= 1'b0;
            r_id   <= 16'd0;
            r_err  <= 1'b0;
            r_data <= 128'd0;
          end else begin
            r_vld  <= w_vld[gi-1];
            r_id   <= w_id[gi-1];
            r_err  <= w_errs[gi-1];
            r_data <= w_data[gi-1];
          end
        end
        assign w_data[gi] = r_data;
      end

      assign w_vld[gi]  = r_vld;
      assign w_id[gi]   = r_id;
      assign w_errs[gi] = r_err;
    end
  endgenerate

  assign inport.inport_accept_o    = r_accept;
  assign inport.inport_ack_o       = w_vld[RESP_LATENCY-1];
  assign inport.inport_error_o     = w_errs[RESP_LATENCY-1];
  assign inport.inport_resp_id_o   = w_id[RESP_LATENCY-1];
  assign inport.inport_read_data_o = w_data[RESP_LATENCY-1];
endmodule

// File: tb/tb_ram_inport_responder.sv
// Directed bench for ram_inport_responder.
// dut_a uses ACCEPT_GAP=0 and carries most scenarios. dut_b uses ACCEPT_GAP=2
// and only checks the throttle.
module tb_ram_inport_responder;
  localparam logic [127:0] D0   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] D16  = 128'hbeaffeadd0d0600d5555AAAA00000000;
  localparam logic [127:0] D32  = 128'hffffffff111111112222222233333333;
  localparam logic [127:0] D0M  = 128'hffeeddccbbaa998877665544332211ff;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_inport_responder_if ifa ();
  ram_inport_responder_if ifb ();

  ram_inport_responder #(.DEPTH_W(6), .RESP_LATENCY(4), .ACCEPT_GAP(0)) dut_a (
    .clk_i (clk), .rst_i (rst), .inport (ifa)
  );
  ram_inport_responder #(.DEPTH_W(6), .RESP_LATENCY(4), .ACCEPT_GAP(2)) dut_b (
    .clk_i (clk), .rst_i (rst), .inport (ifb)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  int           acc_q  [$];
  int           q_cyc  [$];
  logic [15:0]  q_id   [$];
  logic         q_err  [$];
  logic [127:0] q_data [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ack on dut_a. In non-ack cycles, the response fields must be zero.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ifa.inport_ack_o === 1'b1) begin
        q_cyc.push_back(cyc);
        q_id.push_back(ifa.inport_resp_id_o);
        q_err.push_back(ifa.inport_error_o);
        q_data.push_back(ifa.inport_read_data_o);
      end else begin
        total++;
        if ({ifa.inport_error_o, ifa.inport_resp_id_o, ifa.inport_read_data_o} !== '0) begin
          bad++;
          $display("FAIL idle_zero cyc=%0d err=%b id=%h data=%h required all 0", cyc,
                   ifa.inport_error_o, ifa.inport_resp_id_o, ifa.inport_read_data_o);
        end
      end
    end
  end

  task automatic clear_q();
    acc_q.delete(); q_cyc.delete(); q_id.delete(); q_err.delete(); q_data.delete();
  endtask

  // Present a request at a negedge and hold it until accept is seen high.
  task automatic do_req(input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                        input logic [127:0] wd, input logic [15:0] id);
    bit got;
    got = 1'b0;
    @(negedge clk);
    ifa.inport_wr_i = wr;
    ifa.inport_rd_i = rd;
    ifa.inport_addr_i = addr;
    ifa.inport_write_data_i = wd;
    ifa.inport_req_id_i = id;
    for (int i = 0; i < 20; i++) begin
      if (ifa.inport_accept_o === 1'b1) begin
        got = 1'b1;
        acc_q.push_back(cyc);
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout id=%0d accept=%b required 1", id, ifa.inport_accept_o);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ifa.inport_wr_i = '0; ifa.inport_rd_i = 1'b0; ifa.inport_addr_i = '0;
    ifa.inport_write_data_i = '0; ifa.inport_req_id_i = '0;
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 60; i++) begin
      if (q_id.size() >= n) break;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    ifa.inport_wr_i = '0; ifa.inport_rd_i = 1'b0; ifa.inport_addr_i = '0;
    ifa.inport_write_data_i = '0; ifa.inport_req_id_i = '0;
    ifb.inport_wr_i = '0; ifb.inport_rd_i = 1'b0; ifb.inport_addr_i = '0;
    ifb.inport_write_data_i = '0; ifb.inport_req_id_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ifa.inport_accept_o !== 1'b0) begin bad++; $display("FAIL rst_accept got=%b want=0", ifa.inport_accept_o); end
    total++; if (ifa.inport_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", ifa.inport_ack_o); end
    total++; if (ifa.inport_error_o !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", ifa.inport_error_o); end
    total++; if (ifa.inport_resp_id_o !== 16'd0) begin bad++; $display("FAIL rst_resp_id got=%h want=0", ifa.inport_resp_id_o); end
    total++; if (ifa.inport_read_data_o !== 128'd0) begin bad++; $display("FAIL rst_read_data got=%h want=0", ifa.inport_read_data_o); end
    rst = 1'b0;
    #1;
    total++; if (ifa.inport_accept_o !== 1'b0) begin bad++; $display("FAIL rst_release_accept got=%b want=0", ifa.inport_accept_o); end
    @(negedge clk);
    total++; if (ifa.inport_accept_o !== 1'b1) begin bad++; $display("FAIL first_edge_accept got=%b want=1", ifa.inport_accept_o); end
    mon_on = 1'b1;
  endtask

  task automatic test_write_read();
    logic [15:0]  eid [2];
    logic         eer [2];
    logic [127:0] edt [2];
    eid = '{16'd1, 16'd2}; eer = '{1'b0, 1'b0}; edt = '{128'd0, D0};
    clear_q();
    do_req(16'hFFFF, 1'b0, 32'h0, D0, 16'd1);
    do_req(16'h0000, 1'b1, 32'h0, 128'd0, 16'd2);
    idle();
    wait_acks(2);
    total++; if (q_id.size() != 2) begin bad++; $display("FAIL wr_rd_count got=%0d want=2", q_id.size()); end
    for (int i = 0; i < 2 && i < q_id.size() && i < acc_q.size(); i++) begin
      total++; if (q_id[i] !== eid[i]) begin bad++; $display("FAIL wr_rd_id[%0d] got=%h want=%h", i, q_id[i], eid[i]); end
      total++; if (q_err[i] !== eer[i]) begin bad++; $display("FAIL wr_rd_err[%0d] got=%b want=%b", i, q_err[i], eer[i]); end
      total++; if (q_data[i] !== edt[i]) begin bad++; $display("FAIL wr_rd_data[%0d] got=%h want=%h", i, q_data[i], edt[i]); end
      total++; if (q_cyc[i] - acc_q[i] != 4) begin bad++; $display("FAIL wr_rd_latency[%0d] got=%0d want=4", i, q_cyc[i] - acc_q[i]); end
    end
  endtask

  task automatic test_two_words();
    logic [15:0]  eid [4];
    logic [127:0] edt [4];
    eid = '{16'd3, 16'd4, 16'd5, 16'd6}; edt = '{128'd0, 128'd0, D16, D32};
    clear_q();
    do_req(16'hFFFF, 1'b0, 32'd16, D16, 16'd3);
    do_req(16'hFFFF, 1'b0, 32'd32, D32, 16'd4);
    do_req(16'h0000, 1'b1, 32'd16, 128'd0, 16'd5);
    do_req(16'h0000, 1'b1, 32'd32, 128'd0, 16'd6);
    idle();
    wait_acks(4);
    total++; if (q_id.size() != 4) begin bad++; $display("FAIL two_count got=%0d want=4", q_id.size()); end
    for (int i = 0; i < 4 && i < q_id.size(); i++) begin
      total++; if (q_id[i] !== eid[i]) begin bad++; $display("FAIL two_id[%0d] got=%h want=%h", i, q_id[i], eid[i]); end
      total++; if (q_err[i] !== 1'b0) begin bad++; $display("FAIL two_err[%0d] got=%b want=0", i, q_err[i]); end
      total++; if (q_data[i] !== edt[i]) begin bad++; $display("FAIL two_data[%0d] got=%h want=%h", i, q_data[i], edt[i]); end
    end
  endtask

  task automatic test_byte_mask();
    clear_q();
    do_req(16'h0001, 1'b0, 32'h0, ONES, 16'd7);
    do_req(16'h0000, 1'b1, 32'h0, 128'd0, 16'd8);
    idle();
    wait_acks(2);
    total++; if (q_id.size() != 2) begin bad++; $display("FAIL mask_count got=%0d want=2", q_id.size()); end
    if (q_id.size() == 2) begin
      total++; if (q_data[0] !== 128'd0) begin bad++; $display("FAIL mask_wr_data got=%h want=0", q_data[0]); end
      total++; if (q_id[1] !== 16'd8) begin bad++; $display("FAIL mask_rd_id got=%h want=0008", q_id[1]); end
      total++; if (q_data[1] !== D0M) begin bad++; $display("FAIL mask_rd_data got=%h want=%h", q_data[1], D0M); end
    end
  endtask

  task automatic test_errors();
    logic [15:0]  eid [4];
    logic         eer [4];
    logic [127:0] edt [4];
    eid = '{16'd9, 16'd10, 16'd11, 16'd12};
    eer = '{1'b1, 1'b1, 1'b1, 1'b0};
    edt = '{128'd0, 128'd0, 128'd0, D0M};
    clear_q();
    do_req(16'h0000, 1'b1, 32'h0000_0400, 128'd0, 16'd9);
    do_req(16'hFFFF, 1'b1, 32'h0, ONES, 16'd10);
    do_req(16'hFFFF, 1'b0, 32'h0000_0400, ONES, 16'd11);
    do_req(16'h0000, 1'b1, 32'h0, 128'd0, 16'd12);
    idle();
    wait_acks(4);
    total++; if (q_id.size() != 4) begin bad++; $display("FAIL err_count got=%0d want=4", q_id.size()); end
    for (int i = 0; i < 4 && i < q_id.size(); i++) begin
      total++; if (q_id[i] !== eid[i]) begin bad++; $display("FAIL err_id[%0d] got=%h want=%h", i, q_id[i], eid[i]); end
      total++; if (q_err[i] !== eer[i]) begin bad++; $display("FAIL err_flag[%0d] got=%b want=%b", i, q_err[i], eer[i]); end
      total++; if (q_data[i] !== edt[i]) begin bad++; $display("FAIL err_data[%0d] got=%h want=%h", i, q_data[i], edt[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0]  eid [4];
    logic [127:0] edt [4];
    eid = '{16'd20, 16'd21, 16'd22, 16'd23}; edt = '{D0M, D16, D32, D0M};
    clear_q();
    do_req(16'h0000, 1'b1, 32'd0, 128'd0, 16'd20);
    do_req(16'h0000, 1'b1, 32'd16, 128'd0, 16'd21);
    do_req(16'h0000, 1'b1, 32'd32, 128'd0, 16'd22);
    do_req(16'h0000, 1'b1, 32'd0, 128'd0, 16'd23);
    idle();
    wait_acks(4);
    total++; if (q_id.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", q_id.size()); end
    for (int i = 0; i < 4 && i < q_id.size() && i < acc_q.size(); i++) begin
      total++; if (q_id[i] !== eid[i]) begin bad++; $display("FAIL b2b_id[%0d] got=%h want=%h", i, q_id[i], eid[i]); end
      total++; if (q_data[i] !== edt[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, q_data[i], edt[i]); end
      total++; if (q_cyc[i] - q_cyc[0] != i) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, q_cyc[i] - q_cyc[0], i); end
      total++; if (acc_q[i] - acc_q[0] != i) begin bad++; $display("FAIL b2b_accept[%0d] got=%0d want=%0d", i, acc_q[i] - acc_q[0], i); end
    end
  endtask

  task automatic test_accept_gap();
    logic exp_acc [9];
    logic exp_ack [9];
    exp_acc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    ifb.inport_rd_i = 1'b1; ifb.inport_addr_i = 32'd0; ifb.inport_req_id_i = 16'd40;
    for (int k = 0; k < 9; k++) begin
      total++; if (ifb.inport_accept_o !== exp_acc[k]) begin bad++; $display("FAIL gap_accept[%0d] got=%b want=%b", k, ifb.inport_accept_o, exp_acc[k]); end
      total++; if (ifb.inport_ack_o !== exp_ack[k]) begin bad++; $display("FAIL gap_ack[%0d] got=%b want=%b", k, ifb.inport_ack_o, exp_ack[k]); end
      @(negedge clk);
    end
    ifb.inport_rd_i = 1'b0; ifb.inport_req_id_i = 16'd0;
  endtask

  task automatic test_reset_inflight();
    clear_q();
    do_req(16'h0000, 1'b1, 32'd0, 128'd0, 16'd30);
    do_req(16'h0000, 1'b1, 32'd16, 128'd0, 16'd31);
    do_req(16'h0000, 1'b1, 32'd32, 128'd0, 16'd32);
    @(negedge clk);
    ifa.inport_rd_i = 1'b0; ifa.inport_req_id_i = '0; ifa.inport_addr_i = '0;
    rst = 1'b1;
    #1;
    total++; if (ifa.inport_accept_o !== 1'b0) begin bad++; $display("FAIL midrst_accept got=%b want=0", ifa.inport_accept_o); end
    total++; if (ifa.inport_ack_o !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b want=0", ifa.inport_ack_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (q_id.size() != 0) begin bad++; $display("FAIL midrst_stale_acks got=%0d want=0", q_id.size()); end
    clear_q();
    do_req(16'h0000, 1'b1, 32'd16, 128'd0, 16'd33);
    do_req(16'h0000, 1'b1, 32'd0, 128'd0, 16'd34);
    idle();
    wait_acks(2);
    total++; if (q_id.size() != 2) begin bad++; $display("FAIL persist_count got=%0d want=2", q_id.size()); end
    if (q_id.size() == 2) begin
      total++; if (q_id[0] !== 16'd33) begin bad++; $display("FAIL persist_id got=%h want=0021", q_id[0]); end
      total++; if (q_data[0] !== D16) begin bad++; $display("FAIL persist_data16 got=%h want=%h", q_data[0], D16); end
      total++; if (q_data[1] !== D0M) begin bad++; $display("FAIL persist_data0 got=%h want=%h", q_data[1], D0M); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_two_words();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_accept_gap();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
